// File: rtl/axi4_lite_slave_reg_responder_if.sv
// rtl/axi4_lite_slave_reg_responder_if.sv - AXI4-Lite channel bundle for the register responder
interface axi4_lite_slave_reg_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [ADDRESS_WIDTH-1:0]  araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_slave_reg_responder.sv
// rtl/axi4_lite_slave_reg_responder.sv - AXI4-Lite register slave with programmable ready/response delays
module axi4_lite_slave_reg_responder #(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     DATA_WIDTH    = 32,
    parameter int                     DELAY_WIDTH   = 5,
    parameter int                     NUM_REGS      = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = '0,
    parameter bit                     PROT_CHECK    = 1'b1
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    axi4_lite_slave_reg_responder_if.slave      axi,
    input  logic [DELAY_WIDTH-1:0]              cfg_aw_delay,
    input  logic [DELAY_WIDTH-1:0]              cfg_w_delay,
    input  logic [DELAY_WIDTH-1:0]              cfg_ar_delay,
    input  logic [DELAY_WIDTH-1:0]              cfg_b_delay,
    input  logic [DELAY_WIDTH-1:0]              cfg_r_delay,
    input  logic                                cfg_endian,
    output logic [15:0]                         err_count
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam logic [ADDRESS_WIDTH-1:0] SPAN = ADDRESS_WIDTH'(NUM_REGS * STRB_W);
    localparam logic [DELAY_WIDTH-1:0]   ONE  = DELAY_WIDTH'(1);

    typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP_DLY, W_BVALID} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP_DLY, R_RVALID} r_state_e;

    function automatic logic [1:0] decode(input logic [ADDRESS_WIDTH-1:0] addr, input logic prot0);
        logic [ADDRESS_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        if (off >= SPAN)                  return 2'b11;
        if (off[LSB_W-1:0] != '0)         return 2'b10;
        if (PROT_CHECK && !prot0)         return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [IDX_W-1:0] reg_index(input logic [ADDRESS_WIDTH-1:0] addr);
        logic [ADDRESS_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return off[LSB_W +: IDX_W];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rev_data(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        for (int b = 0; b < STRB_W; b++) r[8*b +: 8] = d[8*(STRB_W-1-b) +: 8];
        return r;
    endfunction

    function automatic logic [STRB_W-1:0] rev_strb(input logic [STRB_W-1:0] s);
        logic [STRB_W-1:0] r;
        for (int b = 0; b < STRB_W; b++) r[b] = s[STRB_W-1-b];
        return r;
    endfunction

    logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];
    w_state_e                 w_state_q;
    r_state_e                 r_state_q;
    logic                     awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic                     aw_pend_q, w_pend_q, ar_pend_q, aw_done_q, w_done_q;
    logic [DELAY_WIDTH-1:0]   aw_cnt_q, w_cnt_q, b_cnt_q, ar_cnt_q, r_cnt_q;
    logic [ADDRESS_WIDTH-1:0] awaddr_q;
    logic                     awprot0_q;
    logic [DATA_WIDTH-1:0]    wdata_q, rdata_q;
    logic [STRB_W-1:0]        wstrb_q;
    logic [1:0]               bresp_q, rresp_q;
    logic [15:0]              err_q;

    // AW and W may complete in either order, so use the captured copy once a channel is done
    logic                     aw_hs, w_hs, ar_hs, w_commit, b_set, r_set, b_err, r_err;
    logic [ADDRESS_WIDTH-1:0] awaddr_d;
    logic                     awprot0_d;
    logic [DATA_WIDTH-1:0]    wdata_d, wdata_store, r_data_new;
    logic [STRB_W-1:0]        wstrb_d, wstrb_store;
    logic [1:0]               w_resp_new, r_resp_new;
    logic [IDX_W-1:0]         widx, ridx;

    assign aw_hs       = axi.awvalid && awready_q;
    assign w_hs        = axi.wvalid && wready_q;
    assign ar_hs       = axi.arvalid && arready_q;
    assign awaddr_d    = aw_done_q ? awaddr_q  : axi.awaddr;
    assign awprot0_d   = aw_done_q ? awprot0_q : axi.awprot[0];
    assign wdata_d     = w_done_q  ? wdata_q   : axi.wdata;
    assign wstrb_d     = w_done_q  ? wstrb_q   : axi.wstrb;
    assign wdata_store = cfg_endian ? wdata_d : rev_data(wdata_d);
    assign wstrb_store = cfg_endian ? wstrb_d : rev_strb(wstrb_d);
    assign w_commit    = (w_state_q == W_ADDR_DATA) && (aw_done_q || aw_hs) && (w_done_q || w_hs);
    assign w_resp_new  = decode(awaddr_d, awprot0_d);
    assign widx        = reg_index(awaddr_d);
    assign b_set       = (w_commit && cfg_b_delay == '0) || (w_state_q == W_RESP_DLY && b_cnt_q == ONE);
    assign b_err       = b_set && ((w_commit ? w_resp_new : bresp_q) != 2'b00);

    assign r_resp_new  = decode(axi.araddr, axi.arprot[0]);
    assign ridx        = reg_index(axi.araddr);
    assign r_data_new  = (r_resp_new != 2'b00) ? '0 :
                         (cfg_endian ? regs_q[ridx] : rev_data(regs_q[ridx]));
    assign r_set       = (ar_hs && cfg_r_delay == '0) || (r_state_q == R_RESP_DLY && r_cnt_q == ONE);
    assign r_err       = r_set && ((ar_hs ? r_resp_new : rresp_q) != 2'b00);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;  wready_q <= 1'b0;  bvalid_q <= 1'b0;
            aw_pend_q <= 1'b0;  w_pend_q <= 1'b0;
            aw_done_q <= 1'b0;  w_done_q <= 1'b0;
            aw_cnt_q  <= '0;    w_cnt_q  <= '0;    b_cnt_q  <= '0;
            awaddr_q  <= '0;    awprot0_q <= 1'b0;
            wdata_q   <= '0;    wstrb_q  <= '0;    bresp_q  <= 2'b00;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            case (w_state_q)
                W_IDLE, W_ADDR_DATA: begin
                    if (aw_hs) begin
                        awready_q <= 1'b0;
                        aw_done_q <= 1'b1;
                        awaddr_q  <= axi.awaddr;
                        awprot0_q <= axi.awprot[0];
                    end else if (aw_pend_q) begin
                        if (aw_cnt_q == ONE) begin awready_q <= 1'b1; aw_pend_q <= 1'b0; end
                        else aw_cnt_q <= aw_cnt_q - ONE;
                    end else if (!aw_done_q && !awready_q && axi.awvalid) begin
                        if (cfg_aw_delay == '0) awready_q <= 1'b1;
                        else begin aw_pend_q <= 1'b1; aw_cnt_q <= cfg_aw_delay; end
                    end

                    if (w_hs) begin
                        wready_q <= 1'b0;
                        w_done_q <= 1'b1;
                        wdata_q  <= axi.wdata;
                        wstrb_q  <= axi.wstrb;
                    end else if (w_pend_q) begin
                        if (w_cnt_q == ONE) begin wready_q <= 1'b1; w_pend_q <= 1'b0; end
                        else w_cnt_q <= w_cnt_q - ONE;
                    end else if (!w_done_q && !wready_q && axi.wvalid) begin
                        if (cfg_w_delay == '0) wready_q <= 1'b1;
                        else begin w_pend_q <= 1'b1; w_cnt_q <= cfg_w_delay; end
                    end

                    if (w_state_q == W_IDLE && (axi.awvalid || axi.wvalid)) w_state_q <= W_ADDR_DATA;

                    if (w_commit) begin
                        if (w_resp_new == 2'b00)
                            for (int b = 0; b < STRB_W; b++)
                                if (wstrb_store[b]) regs_q[widx][8*b +: 8] <= wdata_store[8*b +: 8];
                        bresp_q <= w_resp_new;
                        if (cfg_b_delay == '0) begin bvalid_q <= 1'b1; w_state_q <= W_BVALID; end
                        else begin b_cnt_q <= cfg_b_delay; w_state_q <= W_RESP_DLY; end
                    end
                end
                W_RESP_DLY: begin
                    if (b_cnt_q == ONE) begin bvalid_q <= 1'b1; w_state_q <= W_BVALID; end
                    else b_cnt_q <= b_cnt_q - ONE;
                end
                W_BVALID: begin
                    if (axi.bready) begin
                        bvalid_q  <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Register data is taken at the AR edge, so a same-edge write commit is not yet visible
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;  rvalid_q <= 1'b0;  ar_pend_q <= 1'b0;
            ar_cnt_q  <= '0;    r_cnt_q  <= '0;
            rdata_q   <= '0;    rresp_q  <= 2'b00;
        end else begin
            case (r_state_q)
                R_IDLE, R_ADDR: begin
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rresp_q   <= r_resp_new;
                        rdata_q   <= r_data_new;
                        if (cfg_r_delay == '0) begin rvalid_q <= 1'b1; r_state_q <= R_RVALID; end
                        else begin r_cnt_q <= cfg_r_delay; r_state_q <= R_RESP_DLY; end
                    end else begin
                        if (ar_pend_q) begin
                            if (ar_cnt_q == ONE) begin arready_q <= 1'b1; ar_pend_q <= 1'b0; end
                            else ar_cnt_q <= ar_cnt_q - ONE;
                        end else if (!arready_q && axi.arvalid) begin
                            if (cfg_ar_delay == '0) arready_q <= 1'b1;
                            else begin ar_pend_q <= 1'b1; ar_cnt_q <= cfg_ar_delay; end
                        end
                        if (r_state_q == R_IDLE && axi.arvalid) r_state_q <= R_ADDR;
                    end
                end
                R_RESP_DLY: begin
                    if (r_cnt_q == ONE) begin rvalid_q <= 1'b1; r_state_q <= R_RVALID; end
                    else r_cnt_q <= r_cnt_q - ONE;
                end
                R_RVALID: begin
                    if (axi.rready) begin rvalid_q <= 1'b0; r_state_q <= R_IDLE; end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    logic [1:0]  err_inc;
    logic [16:0] err_sum;
    assign err_inc = {1'b0, b_err} + {1'b0, r_err};
    assign err_sum = {1'b0, err_q} + {15'b0, err_inc};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) err_q <= '0;
        else          err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rresp   = rresp_q;
    assign axi.rdata   = rdata_q;
    assign err_count   = err_q;
endmodule

// File: doc/axi4_lite_slave_reg_responder.md
Name: axi4_lite_slave_reg_responder

Overview:
- Parametrised AXI4-Lite slave endpoint: a register array with programmable ready and response delays on both write and read paths.
- Decodes the address into OKAY/SLVERR/DECERR responses, supports big/little-endian byte ordering, and counts error responses.
- Sits behind the slave agent as the RTL responder for AVIP regression and for standalone DUT bring-up.
- One outstanding transaction per direction; the write and read paths run independently.

Parameters:
- ADDRESS_WIDTH, 32, width of awaddr/araddr.
- DATA_WIDTH, 32, data bus width; must be 32 or 64.
- DELAY_WIDTH, 5, width of each delay config port.
- NUM_REGS, 16, number of DATA_WIDTH-bit registers; power of two, ≥2.
- BASE_ADDR, 0, byte address of register 0; aligned to NUM_REGS*DATA_WIDTH/8.
- PROT_CHECK, 1, when 1 an unprivileged access (prot[0]=0) returns SLVERR.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- awaddr  in  ADDRESS_WIDTH  write address.
- awprot  in  3  write protection.
- awvalid  in  1 / awready  out  1  write address handshake.
- wdata  in  DATA_WIDTH / wstrb  in  DATA_WIDTH/8  write data and byte strobes.
- wvalid  in  1 / wready  out  1  write data handshake.
- bresp  out  2 / bvalid  out  1 / bready  in  1  write response channel.
- araddr  in  ADDRESS_WIDTH / arprot  in  3  read address and protection.
- arvalid  in  1 / arready  out  1  read address handshake.
- rdata  out  DATA_WIDTH / rresp  out  2 / rvalid  out  1 / rready  in  1  read data channel.
- cfg_aw_delay, cfg_w_delay, cfg_ar_delay  in  DELAY_WIDTH  ready delays.
- cfg_b_delay, cfg_r_delay  in  DELAY_WIDTH  response delays.
- cfg_endian  in  1  0 = BIG_ENDIAN, 1 = LITTLE_ENDIAN.
- err_count  out  16  saturating count of non-OKAY responses.

Behaviour:
- Reset (asynchronous, aresetn=0):
  - awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; err_count = 0.
  - All registers cleared to 0; both FSMs forced to IDLE.
  - Reset mid-transaction discards it; no response is issued after reset releases.
- All outputs are registered.
- Ready delay:
  - Valid first seen high at edge N → ready high during cycle N+1+d, where d is the config value sampled at edge N.
  - Ready is high for exactly one cycle, then low.
  - The delay counter restarts only on a new valid after handshake.
- Write FSM:
  - States: W_IDLE → W_ADDR_DATA → W_RESP_DLY → W_BVALID → W_IDLE.
  - W_ADDR_DATA: AW and W are captured independently, each with its own delay, in either order.
  - On the edge where the second of the two completes: decode, commit the register write if OKAY, load the cfg_b_delay counter.
  - bvalid asserts after cfg_b_delay cycles, with delay 0 meaning the next cycle.
  - bvalid/bresp hold until bready; then return to W_IDLE.
  - awready/wready are not asserted again until W_IDLE.
- Read FSM:
  - States: R_IDLE → R_ADDR → R_RESP_DLY → R_RVALID → R_IDLE.
  - Register data is sampled at the AR handshake edge.
  - rvalid asserts after cfg_r_delay cycles; rdata/rresp hold until rready.
- Decode, byte offset = addr − BASE_ADDR (unsigned):
  - offset ≥ NUM_REGS*DATA_WIDTH/8 → DECERR (2'b11).
  - else low log2(DATA_WIDTH/8) bits nonzero → SLVERR (2'b10).
  - else PROT_CHECK and prot[0]=0 → SLVERR.
  - else OKAY.
  - DECERR/SLVERR: no register update; rdata = 0. EXOKAY is never produced.
- Write: only bytes with wstrb=1 are updated.
- Endian:
  - cfg_endian=0: wdata and wstrb are byte-reversed before storing; rdata is byte-reversed on output.
  - cfg_endian=1: data passes through.
  - cfg_endian is sampled at the write commit and at the AR handshake.
- Same-edge hazard: a write commit and an AR handshake to the same register on the same edge → the read returns the pre-write value.
- err_count:
  - +1 per non-OKAY response, counted at the edge bvalid or rvalid first asserts.
  - +2 if both assert on the same edge; saturates at 16'hFFFF.
- Valid dropped before handshake is a protocol violation; behaviour undefined; not checked.

Test Plan:
- All delays 0, LE: write 0x0000_0004 ← 0xDEADBEEF, wstrb=F, awprot=1, then read it → awready 1 cycle after awvalid; bvalid OKAY; rdata=0xDEADBEEF, rresp=00.
- cfg_aw_delay=3, cfg_w_delay=7, cfg_b_delay=2, W before AW → wready 8 cycles after wvalid; bvalid 3 cycles after the later handshake.
- BIG_ENDIAN:
  - write 0x11223344, wstrb=4'b0001, then read LE → reg byte3=0x44, read data 0x44000000.
  - read back BE → 0x00000044.
- Error responses:
  - address BASE_ADDR+0x40 (NUM_REGS=16) → DECERR.
  - address 0x2 → SLVERR.
  - arprot=0 → SLVERR, rdata=0.
  - err_count=3; the register array is unchanged.
- Write and read to reg 0 (old 0x5) committing on the same edge with new data 0x9 → read returns 0x5; a subsequent read returns 0x9.
- aresetn low while bvalid waits on bready=0 → bvalid 0 immediately; after release, no stale response; registers and err_count read 0.
